// File: rtl/signed_mac_accum_pkg.sv
// Shared definitions for the signed multiply-accumulate block: FSM encoding and
// saturation bounds for a signed accumulator of a given width.
package signed_mac_accum_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam int BOUND_W = 64;

  // Largest value representable in a w-bit two's-complement number.
  function automatic logic signed [BOUND_W-1:0] acc_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  // Smallest value representable in a w-bit two's-complement number.
  function automatic logic signed [BOUND_W-1:0] acc_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/signed_mac_accum_add.sv
// Combinational signed adder with overflow detect and optional clamp, reusable by
// any accumulator that needs a saturating or wrapping running sum.
module sat_add_signed
  import signed_mac_accum_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = 24,
  parameter int OUT_W = 24,
  parameter int SAT   = 1
) (
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  output logic signed [OUT_W-1:0] sum,
  output logic                    ovf
);

  localparam int MAX_AB = (A_W > B_W) ? A_W : B_W;
  localparam int S_W    = ((MAX_AB > OUT_W) ? MAX_AB : OUT_W) + 1;

  localparam logic signed [OUT_W-1:0] C_MAX = OUT_W'(acc_max(OUT_W));
  localparam logic signed [OUT_W-1:0] C_MIN = OUT_W'(acc_min(OUT_W));

  logic signed [S_W-1:0]   w_a_ext;
  logic signed [S_W-1:0]   w_b_ext;
  logic signed [S_W-1:0]   w_sum;
  logic [S_W-OUT_W:0]      w_top;

  assign w_a_ext = {{(S_W - A_W){a[A_W-1]}}, a};
  assign w_b_ext = {{(S_W - B_W){b[B_W-1]}}, b};
  assign w_sum   = w_a_ext + w_b_ext;

  // The wide sum fits OUT_W exactly when every bit from OUT_W-1 upward matches.
  assign w_top = w_sum[S_W-1:OUT_W-1];
  assign ovf   = !((&w_top) || !(|w_top));

  always_comb begin
    sum = w_sum[OUT_W-1:0];
    if (ovf && (SAT != 0)) begin
      sum = w_sum[S_W-1] ? C_MIN : C_MAX;
    end
  end

endmodule

// File: rtl/signed_mac_accum.sv
// Streams signed products in over valid/ready, sums LEN of them into a saturating
// or wrapping accumulator and presents each result over a second valid/ready port.
module signed_mac_accum
  import signed_mac_accum_pkg::*;
#(
  parameter int P_W   = 16,
  parameter int ACC_W = 24,
  parameter int LEN   = 8,
  parameter int SAT   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [P_W-1:0]             in_p,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           out_acc,
  output logic                       out_ovf,
  output logic [$clog2(LEN+1)-1:0]   count,
  output state_e                     o_dbg_state
);

  // Handshakes: a beat transfers on a rising clk edge where valid && ready are
  // both high; valid never depends on ready, and ready depends only on state.

  localparam int                CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(LEN - 1);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W-1:0] w_acc_nxt;
  logic signed [ACC_W-1:0] r_out_acc;
  logic signed [ACC_W-1:0] w_out_acc_nxt;
  logic                    r_ovf;
  logic                    w_ovf_nxt;
  logic                    r_out_ovf;
  logic                    w_out_ovf_nxt;
  logic [CNT_W-1:0]        r_count;
  logic [CNT_W-1:0]        w_count_nxt;
  logic signed [ACC_W-1:0] w_add_sum;
  logic                    w_add_ovf;

  sat_add_signed #(
    .A_W   (P_W),
    .B_W   (ACC_W),
    .OUT_W (ACC_W),
    .SAT   (SAT)
  ) u_add (
    .a   (in_p),
    .b   (r_acc),
    .sum (w_add_sum),
    .ovf (w_add_ovf)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_ovf_nxt     = r_ovf;
    w_count_nxt   = r_count;
    w_out_acc_nxt = r_out_acc;
    w_out_ovf_nxt = r_out_ovf;

    // clear wins over any same-cycle accept or result handshake.
    if (clear) begin
      w_state_nxt = ACC;
      w_acc_nxt   = '0;
      w_ovf_nxt   = 1'b0;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        ACC: begin
          if (in_valid) begin
            w_acc_nxt   = w_add_sum;
            w_ovf_nxt   = r_ovf | w_add_ovf;
            w_count_nxt = r_count + 1'b1;
            if (r_count == LAST) begin
              w_out_acc_nxt = w_add_sum;
              w_out_ovf_nxt = r_ovf | w_add_ovf;
              w_state_nxt   = HOLD;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            w_state_nxt = ACC;
            w_acc_nxt   = '0;
            w_ovf_nxt   = 1'b0;
            w_count_nxt = '0;
          end
        end
        default: w_state_nxt = ACC;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ACC;
      r_acc     <= '0;
      r_ovf     <= 1'b0;
      r_count   <= '0;
      r_out_acc <= '0;
      r_out_ovf <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_ovf     <= w_ovf_nxt;
      r_count   <= w_count_nxt;
      r_out_acc <= w_out_acc_nxt;
      r_out_ovf <= w_out_ovf_nxt;
    end
  end

  assign in_ready    = (r_state == ACC);
  assign out_valid   = (r_state == HOLD);
  assign out_acc     = r_out_acc;
  assign out_ovf     = r_out_ovf;
  assign count       = r_count;
  assign o_dbg_state = r_state;

endmodule
